// File: rtl/io_pkg.sv
// =============================================================================
// Module      : io_pkg
// Description : Shared constants and helpers for the io_periph I/O window.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package io_pkg;

    localparam logic [31:0] IO_BASE_ADDR = 32'h1000_7000;

    localparam logic [11:0] LEDR_OFF    = 12'h000;
    localparam logic [11:0] LEDG_OFF    = 12'h010;
    localparam logic [11:0] HEXLO_OFF   = 12'h020;
    localparam logic [11:0] HEXHI_OFF   = 12'h024;
    localparam logic [11:0] LCD_OFF     = 12'h030;
    localparam logic [11:0] SW_OFF      = 12'h800;
    localparam logic [11:0] BTN_OFF     = 12'h810;
    localparam logic [11:0] BTNEDGE_OFF = 12'h814;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    localparam logic [31:0] LCD_MASK  = (32'h1 << LCD_ON_BIT) | (32'h1 << LCD_EN_BIT) |
                                        (32'h1 << LCD_RS_BIT) | (32'h1 << LCD_RW_BIT) |
                                        32'h0000_00FF;
    localparam logic [6:0]  HEX_BLANK = 7'h7F;
    localparam logic [31:0] HEX_MASK  = {4{1'b0, HEX_BLANK}};

    // Byte-lane merge of store data into an existing register value.
    function automatic logic [31:0] apply_bmask(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  bmask);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (bmask[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// =============================================================================
// Module      : btn_debounce
// Description : Single active-low button: 2-flop sync, debounce counter,
//               active-high debounced level and press pulse.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw_n,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_toggle;

    assign w_differ = (~r_sync2) != r_level;
    assign w_toggle = w_differ && (r_cnt == c_cnt_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw_n;
            r_sync2 <= r_sync1;
            if (w_toggle) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level = r_level;
    // Pulses during the cycle whose closing edge raises the level.
    assign o_rise  = w_toggle && !r_level;

endmodule

`default_nettype wire

// File: rtl/io_periph.sv
// =============================================================================
// Module      : io_periph
// Description : Memory-mapped LED/HEX/LCD outputs and switch/button inputs.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module io_periph
    import io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = IO_BASE_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    input  logic        i_wren,
    output logic [31:0] o_ld_data,
    output logic        o_hit,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);

    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hexlo;
    logic [31:0] r_hexhi;
    logic [31:0] r_lcd;
    logic [31:0] r_sw_sync1;
    logic [31:0] r_sw_sync2;
    logic [3:0]  r_btnedge;
    logic [3:0]  w_btn_level;
    logic [3:0]  w_btn_rise;
    logic [11:0] w_off;
    logic        w_we;
    logic        w_edge_clr;
    logic        w_unused_addr;

    assign o_hit         = (i_addr[31:12] == BASE_ADDR[31:12]);
    assign w_off         = {i_addr[11:2], 2'b00};
    assign w_we          = i_wren && o_hit;
    assign w_edge_clr    = w_we && (w_off == BTNEDGE_OFF) && i_bmask[0];
    assign w_unused_addr = &{1'b0, i_addr[1:0]};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_raw_n (i_io_btn[k]),
                .o_level (w_btn_level[k]),
                .o_rise  (w_btn_rise[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_hexlo    <= HEX_MASK;
            r_hexhi    <= HEX_MASK;
            r_lcd      <= '0;
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
            r_btnedge  <= '0;
        end else begin
            r_sw_sync1 <= i_io_sw;
            r_sw_sync2 <= r_sw_sync1;
            if (w_we) begin
                case (w_off)
                    LEDR_OFF:  r_ledr  <= apply_bmask(r_ledr, i_st_data, i_bmask);
                    LEDG_OFF:  r_ledg  <= apply_bmask(r_ledg, i_st_data, i_bmask);
                    HEXLO_OFF: r_hexlo <= apply_bmask(r_hexlo, i_st_data, i_bmask) & HEX_MASK;
                    HEXHI_OFF: r_hexhi <= apply_bmask(r_hexhi, i_st_data, i_bmask) & HEX_MASK;
                    LCD_OFF:   r_lcd   <= apply_bmask(r_lcd, i_st_data, i_bmask) & LCD_MASK;
                    default:   ;
                endcase
            end
            // A new press wins over a simultaneous write-1-to-clear.
            r_btnedge <= (w_edge_clr ? (r_btnedge & ~i_st_data[3:0]) : r_btnedge) | w_btn_rise;
        end
    end

    always_comb begin
        o_ld_data = '0;
        if (o_hit) begin
            case (w_off)
                LEDR_OFF:    o_ld_data = r_ledr;
                LEDG_OFF:    o_ld_data = r_ledg;
                HEXLO_OFF:   o_ld_data = r_hexlo;
                HEXHI_OFF:   o_ld_data = r_hexhi;
                LCD_OFF:     o_ld_data = r_lcd;
                SW_OFF:      o_ld_data = r_sw_sync2;
                BTN_OFF:     o_ld_data = {28'h0, w_btn_level};
                BTNEDGE_OFF: o_ld_data = {28'h0, r_btnedge};
                default:     o_ld_data = '0;
            endcase
        end
    end

    assign o_io_ledr = r_ledr;
    assign o_io_ledg = r_ledg;
    assign o_io_lcd  = r_lcd;
    assign o_io_hex0 = r_hexlo[6:0];
    assign o_io_hex1 = r_hexlo[14:8];
    assign o_io_hex2 = r_hexlo[22:16];
    assign o_io_hex3 = r_hexlo[30:24];
    assign o_io_hex4 = r_hexhi[6:0];
    assign o_io_hex5 = r_hexhi[14:8];
    assign o_io_hex6 = r_hexhi[22:16];
    assign o_io_hex7 = r_hexhi[30:24];

endmodule

`default_nettype wire

// File: tb/tb_io_periph.sv
// =============================================================================
// Module      : tb_io_periph
// Description : Directed scoreboard bench for io_periph.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_io_periph;

    localparam logic [31:0] c_base = 32'h1000_7000;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [3:0]  bmask;
    logic        wren;
    logic [31:0] ld_data;
    logic        hit;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [31:0] lcd;
    logic [31:0] sw;
    logic [3:0]  btn;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    io_periph #(
        .DEBOUNCE_CYCLES (16),
        .BASE_ADDR       (c_base)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_addr    (addr),
        .i_st_data (st_data),
        .i_bmask   (bmask),
        .i_wren    (wren),
        .o_ld_data (ld_data),
        .o_hit     (hit),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_hex0 (hex0),
        .o_io_hex1 (hex1),
        .o_io_hex2 (hex2),
        .o_io_hex3 (hex3),
        .o_io_hex4 (hex4),
        .o_io_hex5 (hex5),
        .o_io_hex6 (hex6),
        .o_io_hex7 (hex7),
        .o_io_lcd  (lcd),
        .i_io_sw   (sw),
        .i_io_btn  (btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; inputs change 2 time units after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_val(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed=%h", tag, observed);
        end else begin
            expected = sb.pop_front();
            assert (observed === expected)
            else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr    = a;
        st_data = d;
        bmask   = m;
        wren    = 1'b1;
        tick(1);
        wren    = 1'b0;
        bmask   = 4'h0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
        expect_val(exp_v);
        addr = a;
        #1;
        check(tag, ld_data);
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        st_data = '0;
        bmask   = '0;
        wren    = 1'b0;
        sw      = '0;
        btn     = 4'hF;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        read_chk("rst_ledr",    c_base + 32'h000, 32'h0);
        read_chk("rst_ledg",    c_base + 32'h010, 32'h0);
        read_chk("rst_hexlo",   c_base + 32'h020, 32'h7F7F_7F7F);
        read_chk("rst_hexhi",   c_base + 32'h024, 32'h7F7F_7F7F);
        read_chk("rst_lcd",     c_base + 32'h030, 32'h0);
        read_chk("rst_sw",      c_base + 32'h800, 32'h0);
        read_chk("rst_btn",     c_base + 32'h810, 32'h0);
        read_chk("rst_btnedge", c_base + 32'h814, 32'h0);
        expect_val(32'h7F); check("rst_hex0", {25'h0, hex0});
        expect_val(32'h7F); check("rst_hex7", {25'h0, hex7});
        expect_val(32'h1);  check("hit_in",   {31'h0, hit});

        // Byte-lane stores and out-of-window rejection
        store(c_base, 32'hDEAD_BEEF, 4'b0101);
        expect_val(32'h00AD_00EF); check("ledr_lanes", ledr);
        store(32'h1000_8000, 32'hFFFF_FFFF, 4'hF);
        expect_val(32'h00AD_00EF); check("ledr_miss", ledr);
        addr = 32'h1000_8000; #1;
        expect_val(32'h0); check("hit_out", {31'h0, hit});
        expect_val(32'h0); check("ld_out", ld_data);
        read_chk("unmapped", c_base + 32'h004, 32'h0);
        store(c_base + 32'h013, 32'h1234_5678, 4'hF);
        read_chk("ledg_lowbits", c_base + 32'h010, 32'h1234_5678);

        // HEX registers
        store(c_base + 32'h020, 32'h4079_2430, 4'hF);
        expect_val(32'h30); check("hex0", {25'h0, hex0});
        expect_val(32'h24); check("hex1", {25'h0, hex1});
        expect_val(32'h79); check("hex2", {25'h0, hex2});
        expect_val(32'h40); check("hex3", {25'h0, hex3});
        read_chk("hexlo_rd", c_base + 32'h020, 32'h4079_2430);
        store(c_base + 32'h024, 32'h0000_0000, 4'b0010);
        read_chk("hexhi_lane1", c_base + 32'h024, 32'h7F7F_007F);
        expect_val(32'h00); check("hex5", {25'h0, hex5});
        store(c_base + 32'h020, 32'hFFFF_FFFF, 4'b0001);
        read_chk("hex_bit7", c_base + 32'h020, 32'h4079_247F);
        store(c_base + 32'h030, 32'h8000_0655, 4'hF);
        expect_val(32'h8000_0655); check("lcd", lcd);

        // Switch synchroniser latency and read-only protection
        sw = 32'h0000_A5A5;
        read_chk("sw_0edge", c_base + 32'h800, 32'h0);
        tick(1);
        read_chk("sw_1edge", c_base + 32'h800, 32'h0);
        tick(1);
        read_chk("sw_2edge", c_base + 32'h800, 32'h0000_A5A5);
        store(c_base + 32'h800, 32'hFFFF_FFFF, 4'hF);
        read_chk("sw_ro", c_base + 32'h800, 32'h0000_A5A5);

        // Glitch rejection
        btn[2] = 1'b0;
        tick(10);
        btn[2] = 1'b1;
        tick(25);
        read_chk("glitch_btn",  c_base + 32'h810, 32'h0);
        read_chk("glitch_edge", c_base + 32'h814, 32'h0);

        // Press latency, capture, release, clear
        btn[2] = 1'b0;
        tick(17);
        read_chk("press_17", c_base + 32'h810, 32'h0);
        tick(1);
        read_chk("press_18", c_base + 32'h810, 32'h4);
        read_chk("edge_set", c_base + 32'h814, 32'h4);
        btn[2] = 1'b1;
        tick(25);
        read_chk("released",    c_base + 32'h810, 32'h0);
        read_chk("edge_sticky", c_base + 32'h814, 32'h4);
        store(c_base + 32'h814, 32'h0000_0004, 4'b0001);
        read_chk("edge_clr", c_base + 32'h814, 32'h0);

        // Asynchronous reset mid-debounce
        btn[0] = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        expect_val(32'h0);         check("arst_ledr", ledr);
        expect_val(32'h7F);        check("arst_hex0", {25'h0, hex0});
        expect_val(32'h0);         check("arst_lcd",  lcd);
        read_chk("arst_btn", c_base + 32'h810, 32'h0);
        read_chk("arst_sw",  c_base + 32'h800, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(17);
        read_chk("post_rst_17", c_base + 32'h810, 32'h0);
        tick(1);
        read_chk("post_rst_18", c_base + 32'h810, 32'h1);
        read_chk("post_rst_edge", c_base + 32'h814, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
